avalon_gpio_irq: RTL and testbench

//   Parametrised Avalon-MM GPIO slave; next generation of the output-only PIO.
//   Per-bit direction, input synchronisation, edge capture with interrupt mask, and set/clear output

---
 rtl/avalon_gpio_irq.sv | 74 +++++++
 tb/tb_avalon_gpio_irq.sv | 132 +++++++++++++
 2 files changed

// File: rtl/avalon_gpio_irq.sv
// avalon_gpio_irq: Avalon-MM GPIO slave with per-bit direction, synchronised inputs,
// set/clear output registers and masked edge-capture interrupt.
module avalon_gpio_irq #(
  parameter int          WIDTH       = 8,
  parameter logic [31:0] OUT_RESET   = '0,
  parameter logic [31:0] DIR_RESET   = '0,
  parameter int          EDGE_TYPE   = 0,
  parameter int          SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic             read_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] pio_in,
  output logic [WIDTH-1:0] pio_out,
  output logic [WIDTH-1:0] pio_oe,
  output logic             irq
);
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync;
  logic [WIDTH-1:0] in_sync, prev, data_out, dir, mask, edge_cap, wd, det;
  logic [2:0] prime;
  logic [31:0] rmux;
  logic wr, rd, armed, unused_wd;
  assign wr = chipselect & ~write_n;
  assign rd = chipselect & ~read_n;
  assign wd = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;
  assign in_sync = sync[SYNC_STAGES-1];
  // detection stays off until the synchroniser and prev flops hold real pin values
  assign armed = prime == 3'(SYNC_STAGES + 1);
  assign det = EDGE_TYPE == 0 ? in_sync & ~prev :
               EDGE_TYPE == 1 ? ~in_sync & prev : in_sync ^ prev;
  always_comb begin
    rmux = '0;
    case (address)
      3'd0: rmux = 32'((in_sync & ~dir) | (data_out & dir));
      3'd1: rmux = 32'(dir);
      3'd2: rmux = 32'(mask);
      3'd3: rmux = 32'(edge_cap);
      default: rmux = '0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync     <= '0;
      prev     <= '0;
      prime    <= '0;
      data_out <= OUT_RESET[WIDTH-1:0];
      dir      <= DIR_RESET[WIDTH-1:0];
      mask     <= '0;
      edge_cap <= '0;
      readdata <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pio_in};
      prev <= in_sync;
      if (!armed) prime <= prime + 3'd1;
      data_out <= wr && address == 3'd0 ? wd :
                  wr && address == 3'd4 ? data_out | wd :
                  wr && address == 3'd5 ? data_out & ~wd : data_out;
      if (wr && address == 3'd1) dir <= wd;
      if (wr && address == 3'd2) mask <= wd;
      // a fresh edge wins over a simultaneous write-1-to-clear
      edge_cap <= (edge_cap & ~(wr && address == 3'd3 ? wd : '0)) | (armed ? det : '0);
      if (rd) readdata <= rmux;
    end
  end
  assign irq = |(edge_cap & mask);
  assign pio_out = data_out;
  assign pio_oe = dir;
endmodule

// File: tb/tb_avalon_gpio_irq.sv
// tb_avalon_gpio_irq: directed bench for avalon_gpio_irq, read results checked through an expected-value queue.
module tb_avalon_gpio_irq;
  logic        clk = 0, reset_n = 0, chipselect = 0, write_n = 1, read_n = 1;
  logic [2:0]  address = '0;
  logic [31:0] writedata = '0, readdata;
  logic [7:0]  pio_in = '0, pio_out, pio_oe;
  logic        irq;
  logic [31:0] exp_q[$];
  int total = 0, bad = 0;

  avalon_gpio_irq dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .read_n(read_n), .writedata(writedata), .readdata(readdata),
    .pio_in(pio_in), .pio_out(pio_out), .pio_oe(pio_oe), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1; write_n = 0;
    @(negedge clk);
    chipselect = 0; write_n = 1;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] e, input string tag);
    @(negedge clk);
    address = a; chipselect = 1; read_n = 0;
    exp_q.push_back(e);
    @(negedge clk);
    chipselect = 0; read_n = 1;
    chk(tag, readdata, exp_q.pop_front());
  endtask

  task automatic rw(input logic [2:0] a, input logic [31:0] d, input logic [31:0] e, input string tag);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1; write_n = 0; read_n = 0;
    exp_q.push_back(e);
    @(negedge clk);
    chipselect = 0; write_n = 1; read_n = 1;
    chk(tag, readdata, exp_q.pop_front());
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset_n = 1;
    chk("rst_readdata", readdata, 0);
    chk("rst_oe", 32'(pio_oe), 0);
    chk("rst_out", 32'(pio_out), 0);
    chk("rst_irq", 32'(irq), 0);
    for (int i = 0; i < 8; i++) rd(3'(i), 0, $sformatf("rst_rd%0d", i));
    wr(1, 32'hFF);
    wr(0, 32'h0F);
    wr(4, 32'h30);
    wr(5, 32'h03);
    chk("setclr_out", 32'(pio_out), 32'h3C);
    rd(0, 32'h3C, "setclr_rd_data");
    rd(1, 32'hFF, "rd_dir");
    rd(4, 0, "rd_outset_zero");
    wr(1, 32'hF0);
    wr(0, 32'hA0);
    chk("mixed_oe", 32'(pio_oe), 32'hF0);
    pio_in = 8'h05;
    repeat (4) @(negedge clk);
    rd(0, 32'hA5, "mixed_rd_data");
    rd(3, 32'h05, "edge_after_05");
    chk("irq_masked_off", 32'(irq), 0);
    wr(3, 32'hFF);
    rd(3, 0, "edge_cleared");
    pio_in = 8'h00;
    repeat (4) @(negedge clk);
    rd(3, 0, "fall_not_captured");
    wr(2, 32'h01);
    pio_in = 8'h01;
    @(negedge clk);
    chk("lat_n", 32'(irq), 0);
    @(negedge clk);
    chk("lat_n1", 32'(irq), 0);
    @(negedge clk);
    chk("lat_n2", 32'(irq), 1);
    rd(3, 32'h01, "edge_bit0");
    wr(3, 32'h01);
    chk("irq_cleared", 32'(irq), 0);
    pio_in = 8'h03;
    repeat (4) @(negedge clk);
    chk("irq_bit1_masked", 32'(irq), 0);
    rd(3, 32'h02, "edge_bit1");
    wr(2, 32'h03);
    chk("irq_mask_on", 32'(irq), 1);
    wr(3, 32'h02);
    chk("irq_bit1_clear", 32'(irq), 0);
    pio_in = 8'h02;
    repeat (4) @(negedge clk);
    pio_in = 8'h03;
    @(negedge clk);
    wr(3, 32'h01);
    rd(3, 32'h01, "collision_set_wins");
    chk("collision_irq", 32'(irq), 1);
    rw(2, 32'h01, 32'h03, "rw_pre_write");
    rd(2, 32'h01, "rw_post_write");
    wr(1, 32'hFF);
    wr(0, 32'h3C);
    chk("pre_reset_out", 32'(pio_out), 32'h3C);
    pio_in = 8'hFF;
    @(negedge clk);
    reset_n = 0;
    @(negedge clk);
    chk("mid_reset_out", 32'(pio_out), 0);
    chk("mid_reset_oe", 32'(pio_oe), 0);
    chk("mid_reset_irq", 32'(irq), 0);
    repeat (2) @(negedge clk);
    reset_n = 1;
    repeat (10) @(negedge clk);
    rd(3, 0, "prime_no_false_edge");
    rd(0, 32'hFF, "held_high_data");
    pio_in = 8'h00;
    repeat (4) @(negedge clk);
    pio_in = 8'h80;
    repeat (4) @(negedge clk);
    rd(3, 32'h80, "edge_after_prime");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
